// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver with FIFO.
//   rx_state_e       : receiver FSM states, in frame order
//   PAR_*            : parity-mode encodings for the PARITY parameter
//   EOS_CHAR_DEFAULT : default end-of-string code (carriage return)
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic [7:0] EOS_CHAR_DEFAULT = 8'h0D;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wr_data (ignored when full unless a pop happens the same cycle)
//   pop      : drop the head entry (ignored when empty)
//   flush    : empty the FIFO; takes priority over push and pop
//   wr_data  : entry to write
//   rd_data  : head entry; reads 0 while empty
//   full, empty, count : occupancy status
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // A pop frees the slot a same-cycle push needs, so full only blocks a lone push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH naturally.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is tracked by
  // the pointers and count, and rd_data is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (oversampled, optional parity) feeding a show-ahead FIFO.
//   clk_50mhz, rst : sole clock, asynchronous active-high reset
//   rx_in          : asynchronous serial line, idles high
//   fifo_read      : pop the FIFO head
//   err_clear      : clear the sticky error flags
//   rx_data        : FIFO head
//   rx_valid       : one-cycle pulse when a character is written
//   eos_flag       : one-cycle pulse when the end-of-string code arrives
//   fifo_empty, fifo_full, fifo_count : FIFO status
//   frame_err, parity_err, overflow   : sticky error flags
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int         CLK_FREQ     = 50_000_000,
  parameter int         BAUD_RATE    = 115200,
  parameter int         OVERSAMPLING = 16,
  parameter int         DATA_BITS    = 8,
  parameter int         PARITY       = PAR_NONE,
  parameter int         FIFO_DEPTH   = 32,
  parameter logic [7:0] EOS_CHAR     = EOS_CHAR_DEFAULT,
  parameter int         EOS_FLUSH    = 1
) (
  input  logic                              clk_50mhz,
  input  logic                              rst,
  input  logic                              rx_in,
  input  logic                              fifo_read,
  input  logic                              err_clear,
  output logic [DATA_BITS-1:0]              rx_data,
  output logic                              rx_valid,
  output logic                              eos_flag,
  output logic                              fifo_empty,
  output logic                              fifo_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              frame_err,
  output logic                              parity_err,
  output logic                              overflow
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLING);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W    = $clog2(OVERSAMPLING);
  localparam logic [DATA_BITS-1:0] EOS_CODE = EOS_CHAR[DATA_BITS-1:0];

  rx_state_e            state_q, state_d;
  logic                 sync1_q, sync1_d, sync2_q, sync2_d, rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [OS_W-1:0]      os_q, os_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 pend_q, pend_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overflow_q, overflow_d;

  logic rx_s, tick, mid_start, mid_bit, exp_par, set_frame, set_par;
  logic is_eos, fifo_push, fifo_flush, pop_ok, set_ovf;

  assign rx_s      = sync2_q;
  assign tick      = (div_q == DIV_W'(DIV - 1));
  assign mid_start = tick && (os_q == OS_W'(OVERSAMPLING / 2 - 1));
  assign mid_bit   = tick && (os_q == OS_W'(OVERSAMPLING - 1));
  assign exp_par   = (PARITY == PAR_ODD) ? ~(^shift_q) : (^shift_q);

  always_comb begin
    sync1_d   = rx_in;
    sync2_d   = sync1_q;
    rx_prev_d = sync2_q;
    div_d     = tick ? '0 : div_q + 1'b1;
    os_d      = tick ? os_q + 1'b1 : os_q;
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    pend_d    = 1'b0;
    set_frame = 1'b0;
    set_par   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Restart the divider on the start edge so samples land mid-bit.
        if (rx_prev_q && !rx_s) begin
          state_d = ST_START;
          div_d   = '0;
          os_d    = '0;
        end
      end
      ST_START: begin
        if (mid_start) begin
          os_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            par_bad_d = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (mid_bit) begin
          os_d      = '0;
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'(DATA_BITS - 1))
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (mid_bit) begin
          os_d    = '0;
          state_d = ST_STOP;
          if (rx_s != exp_par) begin
            set_par   = 1'b1;
            par_bad_d = 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (mid_bit) begin
          os_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
            pend_d  = !par_bad_q;
          end else begin
            set_frame = 1'b1;
            state_d   = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A completed character is acted on the cycle after the stop sample;
  // shift_q is stable then because only ST_DATA shifts.
  assign is_eos     = (shift_q == EOS_CODE);
  assign fifo_push  = pend_q && !is_eos;
  assign eos_flag   = pend_q && is_eos;
  assign fifo_flush = eos_flag && (EOS_FLUSH != 0);
  assign pop_ok     = fifo_read && !fifo_empty;
  assign rx_valid   = fifo_push && (!fifo_full || pop_ok);
  assign set_ovf    = fifo_push && fifo_full && !pop_ok;

  // A new error in the same cycle as err_clear wins.
  always_comb begin
    frame_err_d  = set_frame | (frame_err_q & ~err_clear);
    parity_err_d = set_par   | (parity_err_q & ~err_clear);
    overflow_d   = set_ovf   | (overflow_q & ~err_clear);
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      div_q        <= '0;
      os_q         <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      pend_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      rx_prev_q    <= rx_prev_d;
      div_q        <= div_d;
      os_q         <= os_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      pend_q       <= pend_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overflow_q   <= overflow_d;
    end
  end

  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overflow   = overflow_q;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_50mhz),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_read),
    .flush   (fifo_flush),
    .wr_data (shift_q),
    .rd_data (rx_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: an 8N1 instance (a) and an even-parity
// instance (b), both with a 2-cycle tick divider (32 clocks per bit).
module tb_uart_rx_fifo;

  localparam int BIT_CYC = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rx_a, rx_b, rd_a, rd_b, clr_a, clr_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, eos_a, eos_b;
  logic       empty_a, empty_b, full_a, full_b;
  logic [5:0] count_a, count_b;
  logic       ferr_a, ferr_b, perr_a, perr_b, ovf_a, ovf_b;

  uart_rx_fifo #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(31250), .OVERSAMPLING(16),
    .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(32), .EOS_CHAR(8'h0D), .EOS_FLUSH(1)
  ) dut_a (
    .clk_50mhz(clk), .rst(rst), .rx_in(rx_a), .fifo_read(rd_a), .err_clear(clr_a),
    .rx_data(data_a), .rx_valid(valid_a), .eos_flag(eos_a), .fifo_empty(empty_a),
    .fifo_full(full_a), .fifo_count(count_a), .frame_err(ferr_a),
    .parity_err(perr_a), .overflow(ovf_a)
  );

  uart_rx_fifo #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(31250), .OVERSAMPLING(16),
    .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(32), .EOS_CHAR(8'h0D), .EOS_FLUSH(1)
  ) dut_b (
    .clk_50mhz(clk), .rst(rst), .rx_in(rx_b), .fifo_read(rd_b), .err_clear(clr_b),
    .rx_data(data_b), .rx_valid(valid_b), .eos_flag(eos_b), .fifo_empty(empty_b),
    .fifo_full(full_b), .fifo_count(count_b), .frame_err(ferr_b),
    .parity_err(perr_b), .overflow(ovf_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int nv_a     = 0;
  int ne_a     = 0;
  logic [7:0] sb_a [$];

  typedef struct {
    logic [7:0] data;
    logic [5:0] exp_count;
    logic       exp_full;
  } fill_vec_t;
  fill_vec_t fill_tab [32];

  // Pulse counters sample at the falling edge, away from output updates.
  always @(negedge clk) begin
    if (valid_a) nv_a++;
    if (eos_a)   ne_a++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_line(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  // Start, 8 data bits LSB first, optional even parity (optionally inverted),
  // then a stop bit at the requested level, which is left on the line.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit with_par,
                            input bit par_inv, input bit stop_hi);
    drive_line(sel, 1'b0);
    cyc(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      drive_line(sel, d[i]);
      cyc(BIT_CYC);
    end
    if (with_par) begin
      drive_line(sel, (^d) ^ par_inv);
      cyc(BIT_CYC);
    end
    drive_line(sel, stop_hi);
    cyc(BIT_CYC);
    cyc(4);
    #1;
  endtask

  // Compare the head with the scoreboard front, then pop it.
  task automatic pop_check_a(input string name);
    logic [7:0] e;
    @(negedge clk);
    #1;
    if (sb_a.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, head 0x%0h", name, data_a);
    end else begin
      e = sb_a.pop_front();
      check(name, data_a, e);
    end
    rd_a = 1'b1;
    @(negedge clk);
    rd_a = 1'b0;
    #1;
  endtask

  task automatic pulse(input bit sel_clr_b);
    @(negedge clk);
    if (sel_clr_b) clr_b = 1'b1;
    else           clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    clr_b = 1'b0;
    #1;
  endtask

  initial begin
    int nv0, ne0;
    for (int i = 0; i < 32; i++) begin
      fill_tab[i].data      = 8'h10 + 8'(i);
      fill_tab[i].exp_count = 6'(i + 1);
      fill_tab[i].exp_full  = (i == 31);
    end

    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    rd_a = 1'b0; rd_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    cyc(3);
    #1;
    check("rst_empty", empty_a, 1);
    check("rst_full", full_a, 0);
    check("rst_count", count_a, 0);
    check("rst_data", data_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_eos", eos_a, 0);
    check("rst_errs", {ferr_a, perr_a, ovf_a}, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(BIT_CYC);

    // Fill to full from the table.
    for (int i = 0; i < 32; i++) begin
      send_frame(0, fill_tab[i].data, 0, 0, 1);
      sb_a.push_back(fill_tab[i].data);
      check($sformatf("fill_count[%0d]", i), count_a, fill_tab[i].exp_count);
      check($sformatf("fill_full[%0d]", i), full_a, fill_tab[i].exp_full);
    end
    check("fill_valid_pulses", nv_a, 32);
    check("fill_no_ovf", ovf_a, 0);

    // Write while full is dropped.
    send_frame(0, 8'hFF, 0, 0, 1);
    check("ovf_set", ovf_a, 1);
    check("ovf_count", count_a, 32);
    check("ovf_no_valid", nv_a, 32);
    pulse(0);
    check("ovf_clear", ovf_a, 0);

    for (int i = 0; i < 32; i++) pop_check_a($sformatf("drain[%0d]", i));
    check("drain_empty", empty_a, 1);
    check("drain_count", count_a, 0);

    // Read while empty is ignored.
    @(negedge clk); rd_a = 1'b1;
    @(negedge clk); rd_a = 1'b0;
    #1;
    check("underflow_count", count_a, 0);
    check("underflow_empty", empty_a, 1);

    // EOS flushes.
    for (int i = 0; i < 5; i++) begin
      send_frame(0, 8'h41 + 8'(i), 0, 0, 1);
      sb_a.push_back(8'h41 + 8'(i));
    end
    check("eos_pre_count", count_a, 5);
    ne0 = ne_a;
    nv0 = nv_a;
    send_frame(0, 8'h0D, 0, 0, 1);
    sb_a.delete();
    check("eos_pulses", ne_a - ne0, 1);
    check("eos_no_write", nv_a - nv0, 0);
    check("eos_flush_count", count_a, 0);
    check("eos_flush_empty", empty_a, 1);
    send_frame(0, 8'hAA, 0, 0, 1);
    sb_a.push_back(8'hAA);
    check("post_eos_count", count_a, 1);
    pop_check_a("post_eos_head");

    // Even parity on instance b.
    send_frame(1, 8'h55, 1, 0, 1);
    check("par_good_count", count_b, 1);
    check("par_good_err", perr_b, 0);
    send_frame(1, 8'h55, 1, 1, 1);
    check("par_bad_err", perr_b, 1);
    check("par_bad_count", count_b, 1);
    check("par_bad_ferr", ferr_b, 0);
    pulse(1);
    check("par_clear", perr_b, 0);

    // Frame error with the line held low afterwards.
    nv0 = nv_a;
    send_frame(0, 8'h3C, 0, 0, 0);
    cyc(3 * BIT_CYC);
    #1;
    check("ferr_set", ferr_a, 1);
    check("ferr_count", count_a, 0);
    check("ferr_no_write", nv_a - nv0, 0);
    pulse(0);
    cyc(10 * BIT_CYC);
    #1;
    check("ferr_no_restart", ferr_a, 0);
    rx_a = 1'b1;
    cyc(2 * BIT_CYC);
    send_frame(0, 8'h5A, 0, 0, 1);
    sb_a.push_back(8'h5A);
    check("ferr_recover_count", count_a, 1);
    pop_check_a("ferr_recover_head");

    // Short glitch.
    nv0 = nv_a;
    @(negedge clk); rx_a = 1'b0;
    cyc(3);         rx_a = 1'b1;
    cyc(2 * BIT_CYC);
    #1;
    check("glitch_no_valid", nv_a - nv0, 0);
    check("glitch_count", count_a, 0);

    // Reset mid-byte.
    @(negedge clk); rx_a = 1'b0;
    cyc(3 * BIT_CYC);
    rst = 1'b1;
    cyc(2);
    rx_a = 1'b1;
    #1;
    check("midrst_empty", empty_a, 1);
    check("midrst_valid", valid_a, 0);
    @(negedge clk); rst = 1'b0;
    cyc(12 * BIT_CYC);
    #1;
    check("midrst_no_valid", nv_a - nv0, 0);
    check("midrst_count", count_a, 0);
    check("midrst_ferr", ferr_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- CLK_FREQ, 50_000_000, system clock in Hz.
- BAUD_RATE, 115200, line rate.
- OVERSAMPLING, 16, ticks per bit; even, at least 8.
- DATA_BITS, 8, payload width; legal range 5-8.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- FIFO_DEPTH, 32, entries; power of 2, at least 2.
- EOS_CHAR, 8'h0D, end-of-string code, compared on DATA_BITS LSBs.
- EOS_FLUSH, 1, 1 = flush FIFO on EOS, 0 = keep contents.
REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset: one clock; reset is asynchronous and active-high.
- clk_50mhz, in, 1, sole clock.
- rst, in, 1, asynchronous active-high reset.
- rx_in, in, 1, serial line; idles high; asynchronous.
- fifo_read, in, 1, pops the head entry when the FIFO is not empty.
- err_clear, in, 1, clears sticky error flags.
- rx_data, out, DATA_BITS, FIFO head (show-ahead).
- rx_valid, out, 1, one-cycle pulse when a character is written to the FIFO.
- eos_flag, out, 1, one-cycle pulse when EOS_CHAR is received.
- fifo_empty, out, 1, FIFO holds 0 entries.
- fifo_full, out, 1, FIFO holds FIFO_DEPTH entries.
- fifo_count, out, $clog2(FIFO_DEPTH+1), current occupancy.
- frame_err, out, 1, sticky: stop bit sampled low.
- parity_err, out, 1, sticky: parity mismatch.
- overflow, out, 1, sticky: write dropped because the FIFO was full.

Function
REQ-003 rx_in shall pass through a 2-flop synchronizer before any use.
REQ-004 Tick divider shall pulse once every CLK_FREQ/(BAUD_RATE*OVERSAMPLING) cycles (integer division) and restart at 0 on a start edge.
REQ-005 FSM states, in order: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-006 IDLE to START on synchronized falling edge.
REQ-007 START re-samples at tick OVERSAMPLING/2: low goes to DATA; high (glitch) returns to IDLE with no output.
REQ-008 DATA samples each bit at mid-bit, LSB first, for DATA_BITS bits; then PARITY if PARITY!=0, else STOP.
REQ-009 PARITY samples one bit and compares it with the even or odd parity of the payload.
REQ-010 STOP samples mid-bit.
- High: character completes and the FSM returns to IDLE.
- Low: set frame_err, discard the character, go to WAIT_IDLE.
REQ-011 WAIT_IDLE returns to IDLE only after the synchronized line is high.
REQ-012 A parity mismatch shall set parity_err and discard the character.
REQ-013 A completed character equal to EOS_CHAR shall pulse eos_flag, shall not be written to the FIFO, and shall, if EOS_FLUSH=1, reset the FIFO pointers and count in the same cycle.
REQ-014 Any other completed character shall be written one cycle after the stop sample, with rx_valid pulsing in that write cycle.
REQ-015 A write while full shall be dropped and shall set overflow; the receiver keeps running.
REQ-016 Read and write in the same cycle while full: both occur, count unchanged, no overflow.
REQ-017 Read while empty shall be ignored; count shall never underflow.
REQ-018 A flush coinciding with fifo_read: the flush wins and the result is empty.
REQ-019 rx_data shall show the new head in the cycle after a pop edge; its value while empty is don't-care.
REQ-020 Pointers shall wrap modulo FIFO_DEPTH.
REQ-021 err_clear clears frame_err, parity_err and overflow; a set from a new error in the same cycle wins.

Reset
REQ-022 rst shall drive the FSM to IDLE, clear the divider, preset the synchronizer to 1, and set pointers/count to 0.
REQ-023 During rst: fifo_empty=1, fifo_full=0, fifo_count=0, rx_data=0, and every pulse and flag output =0.
REQ-024 Reset asserted mid-frame shall abandon the frame; no partial write occurs.

Structure
REQ-025 Package uart_pkg shall hold the FSM state enum, the parity-mode constants (PAR_NONE/EVEN/ODD) and the default EOS_CHAR.
REQ-026 FIFO storage shall be a sub-module sync_fifo (params WIDTH, DEPTH; push, pop, flush, full, empty, count); the receiver FSM and divider stay in uart_rx_fifo.

Verification
REQ-027 Send 32 bytes 0x10..0x2F, 8N1 -> fifo_full=1, fifo_count=32, rx_valid pulses 32 times, overflow=0.
REQ-028 Send 0xFF while full -> overflow=1, count stays 32; 32 pops return 0x10..0x2F in order, then fifo_empty=1.
REQ-029 Fill with 5 bytes, then send 0x0D (EOS_FLUSH=1) -> eos_flag pulses once, fifo_count=0; then send 0xAA -> rx_data=0xAA.
REQ-030 PARITY=1, send 0x55 with its parity bit inverted -> parity_err=1, count unchanged; err_clear -> parity_err=0.
REQ-031 Send 0x3C with the stop bit forced low, then hold the line low for 3 bit times -> frame_err=1, no write, no new frame until the line goes high.
REQ-032 Glitch rx_in low for 3 cycles, and separately assert rst mid-byte -> no rx_valid, count=0.
